mtm_alu_pkt_gen: RTL
====================

// Module: mtm_alu_pkt_gen
// PURPOSE
//  Synthesizable, parametrised packet generator for the MTM ALU serial input. Successor of the
//  sim-only stimulus driver. Accepts an operand pair + opcode over valid/ready and computes CRC-4.
//  Serialises data/cmd frames onto sin, with optional error injection. Sits between an on-chip
//  stimulus source (LFSR/ROM) and the ALU sin pin.
// PARAMETERS
//  N_BYTES      4  bytes per operand; W = 8*N_BYTES
//  CLK_PER_BIT  1  clocks each serial bit is held (>=1)
//  CNT_W        16 width of pkt_count
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  req_valid  in   1      request present
//  req_ready  out  1      generator idle, can accept
//  a_in       in   W      operand A
//  b_in       in   W      operand B
//  op_in      in   3      ALU opcode
//  err_mode   in   2      00 normal, 01 bad CRC, 10 drop last data frame, 11 extra data frame
//  sin        out  1      serial stream to ALU, idle high
//  busy       out  1      packet in progress (CRC or SEND)
//  done       out  1      1-cycle pulse after last stop bit
//  pkt_count  out  CNT_W  completed packets, wraps
// BEHAVIOUR
//  Reset values: sin=1, req_ready=0 during rst, busy=0, done=0, pkt_count=0, state=IDLE.
//    req_ready=1 first cycle after rst drops.
//  Reset mid-packet: next cycle sin=1, IDLE, counters cleared. No partial frame completion.
//  Handshake: transfer on req_valid&req_ready at edge t0. a_in, b_in, op_in, err_mode registered.
//    req_ready=0 from t0+1 until back in IDLE. req_valid while busy is ignored.
//  FSM IDLE -> CRC -> SEND -> DONE -> IDLE.
//  CRC state: L = 2*W+4 cycles, bit-serial over {B, A, 1'b1, op}, MSB first.
//    Poly x^4+x+1, init 0. Per bit: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 0).
//  err_mode=01: transmitted crc[0] inverted. The internal CRC value is not altered.
//  Frame, 11 bits, sent in this order: start 0, type (0 data / 1 cmd), 8 data bits MSB first, stop 1.
//    Each bit held CLK_PER_BIT clocks. No gap between frames.
//  Frame order:
//    - B bytes MSB byte first, then A bytes MSB byte first.
//    - Then cmd byte {1'b0, op[2:0], crc[3:0]}.
//  Frame count F by err_mode:
//    - normal: 2*N_BYTES+1.
//    - err_mode=10: omits the final A byte, F = 2*N_BYTES.
//    - err_mode=11: repeats the final A byte once before cmd, F = 2*N_BYTES+2.
//  Timing, CPB = CLK_PER_BIT:
//    - CRC active t0+1 .. t0+L.
//    - First start bit driven t0+L+1.
//    - sin carries 11*F*CPB cycles of bits.
//  DONE: lasts exactly one cycle, the cycle after the final stop bit.
//    In that cycle: done=1, busy=0, sin=1, pkt_count increments.
//    IDLE (req_ready=1) the following cycle.
//  pkt_count wraps all-ones -> 0. Reset clears it. Error-injected packets are counted.
//  busy=1 exactly in CRC and SEND states.
//  Bit/frame/byte counters are sized from the parameters; no overflow within a packet.
// TESTING
//  1. N=4, CPB=1, A=0, B=0, op=000, err=00:
//     CRC=4'b1011, cmd byte 8'h0B, 99 sin bits starting t0+69, done at t0+168.
//  2. A=32'h01020304, B=32'hA0B0C0D0, op=001:
//     Decoded data bytes A0,B0,C0,D0,01,02,03,04 with type=0.
//     Cmd type=1 and CRC equals the team crc4 function.
//  3. Case 1 with err=01 -> cmd byte 8'h0A.
//     err=10 -> 8 frames, 88 bits.
//     err=11 -> 10 frames, 9th data byte = 8'h00.
//  4. CPB=4, case 1: each bit held 4 clocks; done at t0+69+396.
//  5. rst asserted during 3rd frame:
//     sin=1 next cycle, busy=0, pkt_count=0, next request starts a clean packet.
//  6. req_valid held high for 3 packets back-to-back:
//     exactly one accept per IDLE cycle, pkt_count=3.
//     Repeat with pkt_count preset near wrap (CNT_W=2 build): 3 -> 0.

Source files
------------

// File: rtl/mtm_alu_pkt_gen.sv
// mtm_alu_pkt_gen: CRC-4 + serial frame generator for the MTM ALU sin input.
// Ports: clk, rst (sync, high), req_valid/req_ready handshake, a_in, b_in,
//   op_in, err_mode in; sin (idle high), busy, done (1-cycle), pkt_count out.
module mtm_alu_pkt_gen #(
    parameter int N_BYTES     = 4,
    parameter int CLK_PER_BIT = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [8*N_BYTES-1:0]   a_in,
    input  logic [8*N_BYTES-1:0]   b_in,
    input  logic [2:0]             op_in,
    input  logic [1:0]             err_mode,
    output logic                   sin,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       pkt_count
);

    localparam int W     = 8 * N_BYTES;
    localparam int L     = 2 * W + 4;
    localparam int CRC_W = $clog2(L);
    localparam int DIV_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int FR_W  = $clog2(2 * N_BYTES + 2);

    localparam logic [CRC_W-1:0] CRC_LAST = CRC_W'(L - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BIT - 1);
    localparam logic [FR_W-1:0]  F_NORM   = FR_W'(2 * N_BYTES);
    localparam logic [FR_W-1:0]  F_DROP   = FR_W'(2 * N_BYTES - 1);
    localparam logic [FR_W-1:0]  F_XTRA   = FR_W'(2 * N_BYTES + 1);
    localparam logic [FR_W-1:0]  REP_IDX  = FR_W'(2 * N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CRC,
        S_SEND,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Message {B, A, 1, op}: rotated through the CRC so it is intact
    // again for SEND, then shifted a byte at a time as frames go out.
    logic [L-1:0]     msg_sr;
    logic [2:0]       op_q;
    logic [1:0]       err_q;
    logic [3:0]       crc;
    logic [CRC_W-1:0] crc_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [FR_W-1:0]  frame_cnt;

    logic [FR_W-1:0]  f_last;
    logic             is_cmd;
    logic             tick;
    logic             bit_end;
    logic             pkt_end;
    logic             hold_byte;
    logic             crc_fb;
    logic [3:0]       crc_nxt;
    logic [7:0]       cmd_byte;
    logic [7:0]       cur_byte;
    logic [10:0]      frame_word;

    always_comb begin
        f_last = F_NORM;
        unique case (err_q)
            2'b10:   f_last = F_DROP;
            2'b11:   f_last = F_XTRA;
            default: f_last = F_NORM;
        endcase
    end

    assign is_cmd    = (frame_cnt == f_last);
    assign tick      = (div_cnt == DIV_LAST);
    assign bit_end   = tick && (bit_cnt == 4'd10);
    assign pkt_end   = bit_end && is_cmd;
    // Last A byte is sent twice in extra-frame mode: keep it one more frame.
    assign hold_byte = (err_q == 2'b11) && (frame_cnt == REP_IDX);

    assign crc_fb  = crc[3] ^ msg_sr[L-1];
    assign crc_nxt = {crc[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);

    // Bad-CRC mode only flips the transmitted bit, never the stored CRC.
    assign cmd_byte   = {1'b0, op_q, crc[3:1], crc[0] ^ (err_q == 2'b01)};
    assign cur_byte   = is_cmd ? cmd_byte : msg_sr[L-1 -: 8];
    assign frame_word = {1'b0, is_cmd, cur_byte, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sin       = 1'b1;
        unique case (state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    state_nxt = S_CRC;
                end
            end
            S_CRC: begin
                busy = 1'b1;
                if (crc_cnt == CRC_LAST) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                busy = 1'b1;
                sin  = frame_word[4'd10 - bit_cnt];
                if (pkt_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_sr    <= '0;
            op_q      <= '0;
            err_q     <= '0;
            crc       <= '0;
            crc_cnt   <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            pkt_count <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        msg_sr    <= {b_in, a_in, 1'b1, op_in};
                        op_q      <= op_in;
                        err_q     <= err_mode;
                        crc       <= '0;
                        crc_cnt   <= '0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        frame_cnt <= '0;
                    end
                end
                S_CRC: begin
                    crc     <= crc_nxt;
                    msg_sr  <= {msg_sr[L-2:0], msg_sr[L-1]};
                    crc_cnt <= crc_cnt + 1'b1;
                end
                S_SEND: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
                    end
                    if (bit_end) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (!hold_byte) begin
                            msg_sr <= {msg_sr[L-9:0], 8'h00};
                        end
                    end
                    if (pkt_end) begin
                        pkt_count <= pkt_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
